// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, flag bit positions and arbiter state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU (add/sub/and/or/slt) producing {Z,N,V,C}; unknown ops give 0
module alu
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int OP_W = 3
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    y,
  output logic [3:0]      flags
);
  logic sub, arith, c, v;
  logic [W-1:0] bx, s;
  always_comb begin
    sub   = op == ALU_SUB || op == ALU_SLT;
    arith = op == ALU_ADD || op == ALU_SUB;
    bx    = sub ? ~b : b;
    {c, s} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    v     = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
    y     = arith ? s :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_SLT ? {{(W-1){1'b0}}, s[W-1] ^ v} : '0;
    // V and C are only meaningful for add/sub; C is the carry-out (1 = no borrow on sub)
    flags         = '0;
    flags[FLAG_Z] = y == '0;
    flags[FLAG_N] = y[W-1];
    flags[FLAG_V] = arith && v;
    flags[FLAG_C] = arith && c;
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU between two requesters with a tagged response
// Optional grant counters enabled by ALU_SHARE_ARB_STATS_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
`ifdef ALU_SHARE_ARB_STATS_EN
  output logic [3:0]        rsp_flags,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`else
  output logic [3:0]        rsp_flags
`endif
);
  arb_state_e state_q, state_d;
  logic last_q, last_d, rid_q, rid_d, g1, acc;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, y;
  logic [OP_W-1:0] op_q, op_d;
  logic [3:0] flags_q, flags_d, flags;
  alu #(.W(DATA_W), .OP_W(OP_W)) u_alu (.a(a_q), .b(b_q), .op(op_q), .y(y), .flags(flags));
  always_comb begin
    // last_q doubles as the id of the op currently in flight
    g1         = req1_valid && (!req0_valid || !last_q);
    acc        = state_q == IDLE && (req0_valid || req1_valid);
    req0_ready = acc && !g1;
    req1_ready = acc && g1;
    state_d    = acc ? EXEC :
                 state_q == EXEC ? RESP :
                 state_q == RESP && rsp_ready ? IDLE : state_q;
    last_d     = acc ? g1 : last_q;
    a_d        = acc ? (g1 ? req1_a : req0_a) : a_q;
    b_d        = acc ? (g1 ? req1_b : req0_b) : b_q;
    op_d       = acc ? (g1 ? req1_op : req0_op) : op_q;
    res_d      = state_q == EXEC ? y : res_q;
    flags_d    = state_q == EXEC ? flags : flags_q;
    rid_d      = state_q == EXEC ? last_q : rid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      rid_q   <= rid_d;
    end
  end
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = rid_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = cnt0_q + 16'(req0_ready && cnt0_q != 16'hFFFF);
    cnt1_d = cnt1_q + 16'(req1_ready && cnt1_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0] rsp_flags;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  // Drive one op, wait (bounded) for accept and response, then complete the handshake.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic ok, output int lat, output logic rid, output logic [31:0] res,
                       output logic [3:0] fl);
    int n = 0;
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    rsp_ready = 1'b1;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      step(); #1; n++;
    end
    ok = n < 20;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    #1;
    while (!rsp_valid && lat < 20) begin
      step(); #1; lat++;
    end
    ok = ok && lat < 20;
    rid = rsp_id; res = rsp_result; fl = rsp_flags;
    step();
  endtask
  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
        bad++; $display("FAIL reset_ctrl i=%0d got %b want 000", i, {req0_ready, req1_ready, rsp_valid});
      end
      total++;
      if ({rsp_id, rsp_result, rsp_flags} !== 37'd0) begin
        bad++; $display("FAIL reset_rsp i=%0d got id=%b res=%h fl=%b want 0", i, rsp_id, rsp_result, rsp_flags);
      end
      step();
    end
  endtask
  task automatic test_single_add();
    req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000; req0_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL add_grant got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL add_exec got %b want 000", {req0_ready, req1_ready, rsp_valid});
    end
    step(); #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 32'd12, 4'b0000}) begin
      bad++; $display("FAIL add_rsp got v=%b id=%b res=%h fl=%b want v=1 id=0 res=c fl=0000",
                      rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    step(); #1;
    total++;
    if ({rsp_valid, rsp_result} !== {1'b1, 32'd12}) begin
      bad++; $display("FAIL add_hold got v=%b res=%h want v=1 res=c", rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    step(); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL add_done got v=%b want 0", rsp_valid);
    end
    step();
  endtask
  task automatic run_table(input string name, input int cnt, input logic ids[6], input logic [31:0] as[6],
                           input logic [31:0] bs[6], input logic [2:0] ops[6], input logic [31:0] exp_r[6],
                           input logic [3:0] exp_f[6]);
    logic ok, rid;
    int lat;
    logic [31:0] res;
    logic [3:0] fl;
    for (int i = 0; i < cnt; i++) begin
      issue(ids[i], as[i], bs[i], ops[i], ok, lat, rid, res, fl);
      total++;
      if (!ok || lat !== 2) begin
        bad++; $display("FAIL %s_lat i=%0d got ok=%b lat=%0d want ok=1 lat=2", name, i, ok, lat);
      end
      total++;
      if ({rid, res, fl} !== {ids[i], exp_r[i], exp_f[i]}) begin
        bad++; $display("FAIL %s_rsp i=%0d got id=%b res=%h fl=%b want id=%b res=%h fl=%b",
                        name, i, rid, res, fl, ids[i], exp_r[i], exp_f[i]);
      end
    end
  endtask
  task automatic test_ops();
    logic ids[6] = '{1, 0, 1, 0, 1, 0};
    logic [31:0] as[6] = '{32'h7FFFFFFF, 32'h0, 32'hF0F0, 32'h0F, 32'hFFFFFFFF, 32'h10};
    logic [31:0] bs[6] = '{32'h1, 32'h1, 32'hFF00, 32'hF0, 32'h1, 32'h10};
    logic [2:0] ops[6] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b000, 3'b001};
    logic [31:0] er[6] = '{32'h80000000, 32'hFFFFFFFF, 32'hF000, 32'h0, 32'h0, 32'h0};
    logic [3:0] ef[6] = '{4'b0110, 4'b0100, 4'b0000, 4'b1000, 4'b1001, 4'b1001};
    run_table("ops", 6, ids, as, bs, ops, er, ef);
  endtask
  task automatic test_slt_illegal();
    logic ids[6] = '{1, 1, 1, 1, 0, 0};
    logic [31:0] as[6] = '{32'd1, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd9, 32'hFFFF};
    logic [31:0] bs[6] = '{32'd2, 32'd1, 32'd1, 32'd3, 32'd4, 32'hFFFF};
    logic [2:0] ops[6] = '{3'b101, 3'b101, 3'b101, 3'b110, 3'b100, 3'b111};
    logic [31:0] er[6] = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [3:0] ef[6] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    run_table("slt", 6, ids, as, bs, ops, er, ef);
  endtask
  task automatic test_simultaneous();
    int ng = 0;
    int nr = 0;
    logic g[4];
    logic rids[4];
    logic [31:0] rres[4];
    logic [3:0] rfl[4];
    logic exp_id[4] = '{0, 1, 0, 1};
    logic [31:0] exp_r[4] = '{32'd7, 32'hFF, 32'd7, 32'hFF};
    logic [3:0] exp_f[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    rst = 1'b1; step(); rst = 1'b0;
    req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'b001; req0_valid = 1'b1;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b011; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      if (req0_ready && ng < 4) begin g[ng] = 1'b0; ng++; end
      if (req1_ready && ng < 4) begin g[ng] = 1'b1; ng++; end
      if (rsp_valid) begin
        rids[nr] = rsp_id; rres[nr] = rsp_result; rfl[nr] = rsp_flags; nr++;
      end
      if (nr < 4) step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
    total++;
    if (nr !== 4 || ng !== 4) begin
      bad++; $display("FAIL sim_count got rsp=%0d grants=%0d want 4 4", nr, ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({g[i], rids[i], rres[i], rfl[i]} !== {exp_id[i], exp_id[i], exp_r[i], exp_f[i]}) begin
          bad++; $display("FAIL sim_rsp i=%0d got grant=%b id=%b res=%h fl=%b want grant=%b id=%b res=%h fl=%b",
                          i, g[i], rids[i], rres[i], rfl[i], exp_id[i], exp_id[i], exp_r[i], exp_f[i]);
        end
      end
    end
  endtask
  task automatic test_backpressure();
    int n = 0;
    req1_a = 32'hFFFFFFFF; req1_b = 32'd1; req1_op = 3'b000; req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    step();
    req1_valid = 1'b0;
    req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'b000; req0_valid = 1'b1;
    step(); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req0_ready, req1_ready} !== {1'b1, 1'b1, 32'd0, 4'b1001, 2'b00}) begin
        bad++; $display("FAIL bp_hold i=%0d got v=%b id=%b res=%h fl=%b rdy=%b%b want v=1 id=1 res=0 fl=1001 rdy=00",
                        i, rsp_valid, rsp_id, rsp_result, rsp_flags, req0_ready, req1_ready);
      end
      step(); #1;
    end
    rsp_ready = 1'b1;
    step(); #1;
    total++;
    if ({rsp_valid, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release got v=%b req0_ready=%b want v=0 req0_ready=1", rsp_valid, req0_ready);
    end
    step();
    req0_valid = 1'b0;
    #1;
    while (!rsp_valid && n < 20) begin step(); #1; n++; end
    total++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd5}) begin
      bad++; $display("FAIL bp_next got v=%b id=%b res=%h want v=1 id=0 res=5", rsp_valid, rsp_id, rsp_result);
    end
    step();
  endtask
  task automatic test_reset_midop();
    int n = 0;
    req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL mid_accept got %b want 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      bad++; $display("FAIL mid_reset got %b want 000", {rsp_valid, req0_ready, req1_ready});
    end
    step(); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_dropped got v=%b want 0", rsp_valid);
    end
    req0_a = 32'd100; req0_b = 32'd1; req0_op = 3'b001; req0_valid = 1'b1;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL mid_first got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    while (!rsp_valid && n < 20) begin step(); #1; n++; end
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 32'd99, 4'b0001}) begin
      bad++; $display("FAIL mid_rsp got v=%b id=%b res=%h fl=%b want v=1 id=0 res=63 fl=0001",
                      rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    step();
  endtask
  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_slt_illegal();
    test_simultaneous();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
